// File: rtl/gpu_pkg.sv
// Shared definitions for the shared-memory arbiter slice.
//   NCORES : number of gpu_core requesters
//   ADDR_W : shared-memory address width
//   DATA_W : shared-memory data width
//   state_t: arbiter FSM state encoding
package gpu_pkg;

    localparam int NCORES = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        REL    = 2'd3
    } state_t;

endpackage

// File: rtl/sm_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : one request bit per core
//   ptr   : core index where the search starts (wraps modulo NCORES)
//   valid : at least one request bit is set
//   idx   : first requesting core at or after ptr
module rr_pick #(
    parameter int NCORES = 4
) (
    input  logic [NCORES-1:0]         req,
    input  logic [$clog2(NCORES)-1:0] ptr,
    output logic                      valid,
    output logic [$clog2(NCORES)-1:0] idx
);

    localparam int IW = $clog2(NCORES);

    // Walk offsets from the farthest to the nearest so the requester
    // closest to ptr is the one left standing.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        for (int i = NCORES - 1; i >= 0; i--) begin
            int cand;
            cand = (int'(ptr) + i) % NCORES;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/sm_arbiter.sv
// sm_arbiter: grants one gpu_core at a time access to a single-port shared
// SRAM. Each access runs IDLE -> ACCESS -> RESP -> REL and is atomic.
//   clk, reset_n              : clock, synchronous active-low reset
//   mem_req_ld / mem_req_st   : per-core load / store requests (held until val_data)
//   addr_shared_memory        : per-core address, ADDR_W bits per core
//   mem_dat_st                : per-core store data, DATA_W bits per core
//   val_data                  : one-cycle completion pulse to the granted core
//   mem_dat                   : load data broadcast, valid with val_data
//   sm_en/sm_we/sm_addr/sm_wdata/sm_rdata : SRAM port
//   grant_id                  : core currently or last served
//   busy                      : FSM not in IDLE
//   err_req                   : sticky, a granted core had ld and st both high
module sm_arbiter
    import gpu_pkg::*;
#(
    parameter int NCORES = gpu_pkg::NCORES,
    parameter int ADDR_W = gpu_pkg::ADDR_W,
    parameter int DATA_W = gpu_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NCORES-1:0]           mem_req_ld,
    input  logic [NCORES-1:0]           mem_req_st,
    input  logic [NCORES*ADDR_W-1:0]    addr_shared_memory,
    input  logic [NCORES*DATA_W-1:0]    mem_dat_st,
    output logic [NCORES-1:0]           val_data,
    output logic [DATA_W-1:0]           mem_dat,
    output logic                        sm_en,
    output logic                        sm_we,
    output logic [ADDR_W-1:0]           sm_addr,
    output logic [DATA_W-1:0]           sm_wdata,
    input  logic [DATA_W-1:0]           sm_rdata,
    output logic [$clog2(NCORES)-1:0]   grant_id,
    output logic                        busy,
    output logic                        err_req
);

    localparam int IW = $clog2(NCORES);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic            op_st;
    logic [NCORES-1:0] req;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic            grant_now;

    assign req       = mem_req_ld | mem_req_st;
    assign grant_now = (state == IDLE) && pick_vld;

    rr_pick #(
        .NCORES(NCORES)
    ) u_rr_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .valid(pick_vld),
        .idx  (pick_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pick_vld ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = REL;
            REL:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant latch, round-robin pointer, load-data capture and error flag.
    // Address and data are latched in IDLE so later request changes
    // cannot disturb an access in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            op_st    <= 1'b0;
            sm_addr  <= '0;
            sm_wdata <= '0;
            mem_dat  <= '0;
            err_req  <= 1'b0;
        end else begin
            if (grant_now) begin
                grant_id <= pick_idx;
                rr_ptr   <= (pick_idx == IW'(NCORES - 1)) ? '0 : pick_idx + 1'b1;
                // ld wins when both are raised
                op_st    <= mem_req_st[pick_idx] & ~mem_req_ld[pick_idx];
                sm_addr  <= addr_shared_memory[pick_idx*ADDR_W +: ADDR_W];
                sm_wdata <= mem_dat_st[pick_idx*DATA_W +: DATA_W];
                if (mem_req_ld[pick_idx] && mem_req_st[pick_idx]) begin
                    err_req <= 1'b1;
                end
            end
            // SRAM read data is valid the cycle after ACCESS
            if ((state == RESP) && !op_st) begin
                mem_dat <= sm_rdata;
            end
        end
    end

    // Output decode
    always_comb begin
        sm_en    = 1'b0;
        sm_we    = 1'b0;
        val_data = '0;
        busy     = (state != IDLE);
        case (state)
            ACCESS: begin
                sm_en = 1'b1;
                sm_we = op_st;
            end
            REL: begin
                val_data[grant_id] = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
